seq_scan_ctrl: RTL
==================

Name: seq_scan_ctrl

Overview:
Scan controller for the serial "1101" Mealy sequence detector. It accepts parallel words over a valid/ready handshake and shifts each word MSB-first, one bit per cycle, into an owned detector core. It collects a per-bit match mask and a match count, then presents a result record over a second valid/ready handshake. It sits between a word-oriented producer and the bit-serial detection datapath, and sequences that datapath.

Parameters:
W, 8, input word width in bits; legal values are 4 to 32.
CW, $clog2(W+1), count width; a derived localparam, not overridable.

Ports:
clk  in  1  single clock; all state changes on the rising edge.
rst  in  1  asynchronous, active-high reset.
in_valid  in  1  producer has a word.
in_ready  out  1  controller can accept a word.
in_data  in  W  word to scan; bit W-1 is shifted first.
in_cont  in  1  sampled with the word. 1 = stream mode, keep detector state from the previous word. 0 = clear the detector before scanning.
out_valid  out  1  result record valid.
out_ready  in  1  consumer accepts the result.
out_count  out  CW  number of matches in the word.
out_mask  out  W  bit i set = a match completed on input bit i.
busy  out  1  high in SHIFT or REPORT.

Behaviour:
- Reset (async, rst=1):
  - FSM goes to IDLE; detector goes to S0.
  - Outputs: in_ready=0 while rst is high, out_valid=0, out_count=0, out_mask=0, busy=0.
  - in_ready rises in the first cycle after rst deasserts.
- FSM states: IDLE, SHIFT, REPORT.
- IDLE:
  - in_ready=1.
  - On in_valid & in_ready: latch in_data into a shift register and clear the mask and count accumulators.
  - If in_cont=0, synchronously clear the detector to S0 on the same edge.
  - Go to SHIFT with bit index idx=W-1.
- SHIFT:
  - in_ready=0. Each cycle, drive bit idx to the detector with en=1.
  - If the detector match is high, set mask[idx] and increment count.
  - Decrement idx. After processing idx=0, go to REPORT.
  - Takes exactly W cycles.
- REPORT:
  - out_valid=1, holding out_count and out_mask stable.
  - On out_valid & out_ready, go to IDLE; out_valid deasserts on the next cycle.
- Latency: input handshake at edge t; out_valid is high from cycle t+W+1. Throughput is one word per W+2 cycles when out_ready is tied high.
- Detector core:
  - States S0 (idle), S1 (saw "1"), S2 (saw "11"), S3 (saw "110").
  - Transitions:
    - S0: 1->S1, 0->S0.
    - S1: 1->S2, 0->S0.
    - S2: 1->S2, 0->S3.
    - S3: 1->S1 with match, 0->S0.
  - Overlapping matches are allowed.
  - match is a combinational Mealy output: en & (state==S3) & din, so it is counted in the cycle of the completing bit.
  - State advances only when en=1. It holds through IDLE and REPORT, so stream-mode history survives idle gaps of any length.
- Arithmetic: at most floor((W-1)/3)+1 matches per word, so CW bits never overflow. No saturation logic.
- Simultaneous events: in_valid during SHIFT/REPORT is ignored (in_ready=0). The producer must hold its word.
- Backpressure: out_valid stays high indefinitely while out_ready=0. No new input is accepted in that time.
- Reset mid-SHIFT or mid-REPORT: the partial result is discarded and no out_valid pulse is emitted.

Decomposition:
- Shared package seq_pkg:
  - Detector state encoding S0..S3 (2-bit).
  - Controller state encoding IDLE/SHIFT/REPORT (2-bit).
  - Pattern constant 4'b1101 for documentation and benches.
- Sub-module seq_detect_core:
  - Ports: clk, rst, clr, en, din, match.
  - 2-bit state register; async reset to S0; clr has priority over en.
- seq_scan_ctrl holds the FSM, shift register, index counter, mask and count accumulators.

Test Plan:
1. W=8, in_data=0xDD, in_cont=0 -> after 8 SHIFT cycles: out_count=2, out_mask=0x11, out_valid at t+9.
2. in_data=0x03 (cont=0), then 0x40 with cont=1 -> second result: count=1, mask=0x40 (history S2 carried). Repeating with cont=0 on the second word -> count=0, mask=0x00.
3. in_data=0xFF then 0x00 (cont=0) -> count=0, mask=0x00 for both; busy high for exactly 9 cycles each.
4. out_ready held low 5 cycles in REPORT with in_valid=1 -> out_valid and fields stable, in_ready=0, second word accepted only after the out handshake.
5. rst pulsed for 1 cycle at the 4th SHIFT cycle of 0xDD -> immediate out_valid=0, busy=0, in_ready=1 next cycle. Next word 0x0D (cont=1) -> count=1, mask=0x01, proving the detector was reset to S0.
6. Back-to-back 0xDD words with out_ready=1 and cont=1 -> results every 10 cycles, each count=2, mask=0x11.

Source files
------------

// File: rtl/seq_pkg.sv
// seq_pkg: shared encodings for the "1101" scan controller and its detector core.
//   det_state_t  : detector states S0 (idle), S1 ("1"), S2 ("11"), S3 ("110")
//   ctrl_state_t : controller states IDLE, SHIFT, REPORT
//   PATTERN      : the detected bit pattern, first bit at the MSB
package seq_pkg;

    typedef enum logic [1:0] {S0, S1, S2, S3} det_state_t;

    typedef enum logic [1:0] {IDLE, SHIFT, REPORT} ctrl_state_t;

    localparam logic [3:0] PATTERN = 4'b1101;

endpackage

// File: rtl/seq_detect_core.sv
// seq_detect_core: bit-serial Mealy detector for "1101" with overlap.
//   clk   : rising-edge clock
//   rst   : asynchronous active-high reset to S0
//   clr   : synchronous clear to S0, wins over en
//   en    : advance the state on din this cycle
//   din   : serial input bit
//   match : combinational, high in the cycle of the completing bit
module seq_detect_core
    import seq_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    input  logic din,
    output logic match
);

    det_state_t state, state_nx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= S0;
        else if (clr)
            state <= S0;
        else if (en)
            state <= state_nx;
    end

    // After a match the trailing "1" is kept as S1 so overlapping matches are found.
    always_comb begin
        state_nx = S0;
        case (state)
            S0: state_nx = din ? S1 : S0;
            S1: state_nx = din ? S2 : S0;
            S2: state_nx = din ? S2 : S3;
            S3: state_nx = din ? S1 : S0;
            default: state_nx = S0;
        endcase
    end

    assign match = en & (state == S3) & din;

endmodule

// File: rtl/seq_scan_ctrl.sv
// seq_scan_ctrl: accepts words over valid/ready, shifts them MSB-first into the
// "1101" detector and reports a per-bit match mask and match count.
//   clk, rst             : clock, asynchronous active-high reset
//   in_valid/in_ready    : input word handshake
//   in_data              : word to scan, bit W-1 first
//   in_cont              : 1 keeps detector history, 0 clears it before scanning
//   out_valid/out_ready  : result handshake
//   out_count, out_mask  : number of matches, bit i set = match completed on bit i
//   busy                 : high in SHIFT or REPORT
module seq_scan_ctrl
    import seq_pkg::*;
#(
    parameter  int W  = 8,
    localparam int CW = $clog2(W + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_data,
    input  logic          in_cont,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [CW-1:0] out_count,
    output logic [W-1:0]  out_mask,
    output logic          busy
);

    localparam int IW = $clog2(W);

    ctrl_state_t   state, state_nx;
    logic [W-1:0]  sr, mask;
    logic [CW-1:0] count;
    logic [IW-1:0] idx;
    logic          accept, clr, en, din, match;

    assign accept = in_valid & in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = accept ? SHIFT : IDLE;
            SHIFT:   state_nx = (idx == '0) ? REPORT : SHIFT;
            REPORT:  state_nx = out_ready ? IDLE : REPORT;
            default: state_nx = IDLE;
        endcase
    end

    // in_ready is gated by rst so nothing is accepted while reset is held.
    always_comb begin
        in_ready  = (state == IDLE) & ~rst;
        out_valid = state == REPORT;
        busy      = state != IDLE;
        en        = state == SHIFT;
        clr       = accept & ~in_cont;
        din       = sr[idx];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr    <= '0;
            mask  <= '0;
            count <= '0;
            idx   <= '0;
        end else if (accept) begin
            sr    <= in_data;
            mask  <= '0;
            count <= '0;
            idx   <= IW'(W - 1);
        end else if (en) begin
            if (match) begin
                mask[idx] <= 1'b1;
                count     <= count + CW'(1);
            end
            idx <= idx - IW'(1);
        end
    end

    assign out_count = count;
    assign out_mask  = mask;

    seq_detect_core u_core (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .en    (en),
        .din   (din),
        .match (match)
    );

endmodule
